// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl -- sequencer wrapped around a binarized fully-connected layer.
//
// Streams BEATS 16-bit pixel beats into the FC layer. It then waits for the
// layer's result strobe, captures all class scores, and runs an argmax over
// them at one score per cycle. The winning class and score are presented on
// a valid/ready output port.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready : upstream beat handshake, s_data = 16 binarized pixels
//   fc_valid_in     : beat strobe to the FC layer, fc_pixels = beat data
//   fc_valid_out    : FC result strobe, fc_scores = NUM_CLASSES x 9-bit scores
//   m_valid/m_ready : result handshake, m_class = argmax index, m_score = max
//   busy            : frame in progress (any state but FEED, or beats pending)
//   err_timeout     : sticky watchdog flag
//
// Configuration
//   FC_SEQ_TIMEOUT_EN : when defined, WAIT gives up after TIMEOUT_CYCLES
//                       cycles without fc_valid_out, sets err_timeout and
//                       returns to FEED without producing a result. When
//                       undefined, WAIT waits forever and err_timeout is 0.
module fc_seq_ctrl #(
    parameter int BEATS          = 25,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [15:0]              s_data,
    output logic                     fc_valid_in,
    output logic [15:0]              fc_pixels,
    input  logic                     fc_valid_out,
    input  logic [9*NUM_CLASSES-1:0] fc_scores,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [3:0]               m_class,
    output logic [8:0]               m_score,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Scan index runs one past the last class: that extra step publishes
    // the result, which puts m_valid NUM_CLASSES+1 edges after capture.
    localparam int IW = $clog2(NUM_CLASSES + 1);

    typedef enum logic [1:0] {
        FEED = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                       state, state_nx;
    logic [CW-1:0]                beat_cnt, beat_cnt_nx;
    logic [IW-1:0]                scan_idx, scan_idx_nx;
    logic [NUM_CLASSES-1:0][8:0]  scores_r;
    logic                         load_scores;
    logic [8:0]                   best_score, best_score_nx;
    logic [3:0]                   best_idx, best_idx_nx;
    logic [3:0]                   m_class_r, m_class_nx;
    logic [8:0]                   m_score_r, m_score_nx;
    logic [8:0]                   cur_score;
    logic                         timeout_hit;

    // Score under examination this cycle.
    always_comb begin
        cur_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (scan_idx == IW'(k)) cur_score = scores_r[k];
        end
    end

`ifdef FC_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wait_cnt;
    logic          err_r;

    // A result arriving on the last allowed cycle still wins over the watchdog.
    assign timeout_hit = (state == WAIT) && !fc_valid_out &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_r    <= 1'b0;
        end else begin
            if (state == WAIT && !fc_valid_out && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout_hit) err_r <= 1'b1;
        end
    end

    assign err_timeout = err_r;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next state, datapath updates and the upstream/FC-side outputs.
    always_comb begin
        state_nx      = state;
        beat_cnt_nx   = beat_cnt;
        scan_idx_nx   = scan_idx;
        best_score_nx = best_score;
        best_idx_nx   = best_idx;
        m_class_nx    = m_class_r;
        m_score_nx    = m_score_r;
        load_scores   = 1'b0;
        s_ready       = 1'b0;
        fc_valid_in   = 1'b0;
        fc_pixels     = '0;

        case (state)
            FEED: begin
                s_ready     = 1'b1;
                fc_valid_in = s_valid;
                fc_pixels   = s_data;
                if (s_valid) begin
                    if (beat_cnt == CW'(BEATS - 1)) begin
                        beat_cnt_nx = '0;
                        state_nx    = WAIT;
                    end else begin
                        beat_cnt_nx = beat_cnt + 1'b1;
                    end
                end
            end

            WAIT: begin
                if (fc_valid_out) begin
                    load_scores = 1'b1;
                    scan_idx_nx = '0;
                    state_nx    = SCAN;
                end else if (timeout_hit) begin
                    state_nx = FEED;
                end
            end

            SCAN: begin
                if (scan_idx == IW'(NUM_CLASSES)) begin
                    m_class_nx  = best_idx;
                    m_score_nx  = best_score;
                    scan_idx_nx = '0;
                    state_nx    = OUT;
                end else begin
                    // Strict compare: equal scores keep the earlier index.
                    if (scan_idx == '0 || cur_score > best_score) begin
                        best_score_nx = cur_score;
                        best_idx_nx   = 4'(scan_idx);
                    end
                    scan_idx_nx = scan_idx + 1'b1;
                end
            end

            OUT: begin
                if (m_ready) state_nx = FEED;
            end

            default: state_nx = FEED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FEED;
            beat_cnt   <= '0;
            scan_idx   <= '0;
            scores_r   <= '0;
            best_score <= '0;
            best_idx   <= '0;
            m_class_r  <= '0;
            m_score_r  <= '0;
        end else begin
            state      <= state_nx;
            beat_cnt   <= beat_cnt_nx;
            scan_idx   <= scan_idx_nx;
            if (load_scores) scores_r <= fc_scores;
            best_score <= best_score_nx;
            best_idx   <= best_idx_nx;
            m_class_r  <= m_class_nx;
            m_score_r  <= m_score_nx;
        end
    end

    assign m_valid = (state == OUT);
    assign m_class = m_class_r;
    assign m_score = m_score_r;
    assign busy    = (state != FEED) || (beat_cnt != '0);

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Scoreboard bench for fc_seq_ctrl: the stimulus pushes the argmax expected
// for each frame; a negedge monitor compares every presented result.
module tb_fc_seq_ctrl;

    localparam int BEATS = 25;
    localparam int NC    = 10;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [15:0]   s_data = '0;
    logic          fc_valid_in;
    logic [15:0]   fc_pixels;
    logic          fc_valid_out = 1'b0;
    logic [9*NC-1:0] fc_scores = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [3:0]    m_class;
    logic [8:0]    m_score;
    logic          busy;
    logic          err_timeout;

    fc_seq_ctrl #(.BEATS(BEATS), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fc_valid_in(fc_valid_in), .fc_pixels(fc_pixels),
        .fc_valid_out(fc_valid_out), .fc_scores(fc_scores),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_class(m_class), .m_score(m_score),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int score;
    } res_t;

    res_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         pulse_cnt = 0;
    int         hs_cnt = 0;
    int         frame_beats = 0;
    logic [8:0] cur_sc[NC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the largest value, reported at the first index holding it.
    function automatic res_t ref_model();
        res_t r;
        int mx = 0;
        for (int k = 0; k < NC; k++) if (int'(cur_sc[k]) > mx) mx = int'(cur_sc[k]);
        r.score = mx;
        r.cls   = -1;
        for (int k = 0; k < NC; k++) if (r.cls < 0 && int'(cur_sc[k]) == mx) r.cls = k;
        return r;
    endfunction

    function automatic logic [9*NC-1:0] junk_scores();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[9*NC-1:0];
    endfunction

    // Monitor: FC beat counter plus result scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fc_valid_in) pulse_cnt++;
            if (m_valid) begin
                chk("out_s_ready_low", s_ready, 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got class %0d score %0d, expected no result",
                             m_class, m_score);
                end else begin
                    chk("sb_class", m_class, exp_q[0].cls);
                    chk("sb_score", m_score, exp_q[0].score);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    // Feed n accepted beats with random gaps; called at posedge+1.
    task automatic feed(input int n, input int gap_pct);
        int          done;
        logic [15:0] d;
        logic        v;
        done = 0;
        while (done < n) begin
            d       = 16'($urandom);
            v       = ($urandom_range(99) >= gap_pct);
            s_data  = d;
            s_valid = v;
            m_ready = 1'($urandom);
            #1;
            chk("feed_s_ready", s_ready, 1);
            chk("feed_fc_valid_in", fc_valid_in, v);
            chk("feed_pixels", fc_pixels, d);
            @(posedge clk);
            #1;
            if (v) begin
                done++;
                frame_beats++;
                chk("beat_busy", busy, 1);
                if (frame_beats == BEATS) begin
                    frame_beats = 0;
                    chk("frame_end_s_ready", s_ready, 0);
                end else begin
                    chk("mid_frame_s_ready", s_ready, 1);
                end
            end
            s_valid = 1'b0;
        end
        m_ready = 1'b0;
    endtask

    task automatic run_frame(input int gap_pct, input int wait_cyc, input int hold);
        res_t r;
        int   h0;
        pulse_cnt = 0;
        feed(BEATS, gap_pct);
        chk("fc_pulses", pulse_cnt, BEATS);
        // WAIT: upstream blocked even while s_valid is offered.
        repeat (wait_cyc - 1) begin
            s_valid = 1'b1;
            s_data  = 16'($urandom);
            m_ready = 1'($urandom);
            #1;
            chk("wait_s_ready", s_ready, 0);
            chk("wait_fc_valid_in", fc_valid_in, 0);
            chk("wait_pixels", fc_pixels, 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        fc_valid_out = 1'b1;
        for (int k = 0; k < NC; k++) fc_scores[9*k +: 9] = cur_sc[k];
        r = ref_model();
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        // Scan: strobes and don't-care handshakes must not disturb anything.
        for (int i = 1; i <= NC + 1; i++) begin
            fc_valid_out = 1'($urandom);
            fc_scores    = junk_scores();
            m_ready      = 1'($urandom);
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            chk("latency_m_valid", m_valid, (i == NC + 1));
            chk("scan_s_ready", s_ready, 0);
        end
        repeat (hold) begin
            fc_valid_out = 1'($urandom);
            fc_scores    = junk_scores();
            @(posedge clk);
            #1;
            chk("hold_m_valid", m_valid, 1);
        end
        fc_valid_out = 1'b0;
        m_ready      = 1'b1;
        h0           = hs_cnt;
        for (int c = 0; c < 5 && hs_cnt == h0; c++) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        chk("handshake_seen", (hs_cnt != h0), 1);
        chk("post_hs_s_ready", s_ready, 1);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_m_valid", m_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #2 rst_n = 1'b0;
        #10;
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_class", m_class, 0);
        chk("rst_m_score", m_score, 0);
        chk("rst_err", err_timeout, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Clear maximum in the middle, long back-pressure on the result.
        for (int k = 0; k < NC; k++) cur_sc[k] = 9'd0;
        cur_sc[0] = 9'd100; cur_sc[1] = 9'd150; cur_sc[2] = 9'd210; cur_sc[3] = 9'd90;
        run_frame(0, 2, 20);

        // Tie between index 3 and 7: lowest index wins.
        for (int k = 0; k < NC; k++) cur_sc[k] = 9'($urandom_range(204));
        cur_sc[3] = 9'd205; cur_sc[7] = 9'd205;
        run_frame(30, 2, 3);

        // Values above 255 must compare as full 9-bit unsigned.
        for (int k = 0; k < NC; k++) cur_sc[k] = 9'd255;
        cur_sc[9] = 9'd256; cur_sc[5] = 9'd511;
        run_frame(10, 3, 0);

        // Reset after 12 beats discards the partial frame.
        feed(12, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        frame_beats = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < NC; k++) cur_sc[k] = 9'($urandom_range(400));
        run_frame(0, 2, 1);

`ifdef FC_SEQ_TIMEOUT_EN
        // Withheld result: watchdog fires on the 16th WAIT cycle.
        feed(BEATS, 0);
        for (int j = 1; j <= TO; j++) begin
            @(posedge clk);
            #1;
            if (j < TO) begin
                chk("to_pending_err", err_timeout, 0);
                chk("to_pending_s_ready", s_ready, 0);
            end
        end
        chk("to_err", err_timeout, 1);
        chk("to_s_ready", s_ready, 1);
        chk("to_m_valid", m_valid, 0);
        chk("to_busy", busy, 0);
`else
        // Without the watchdog, a long wait still completes normally.
        for (int k = 0; k < NC; k++) cur_sc[k] = 9'($urandom_range(400));
        run_frame(0, 40, 0);
`endif

        // Random frames, some with heavy ties.
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < NC; k++)
                cur_sc[k] = (f % 3 == 0) ? 9'($urandom_range(3)) : 9'($urandom_range(511));
            run_frame($urandom_range(50), $urandom_range(8, 2), $urandom_range(5));
        end

`ifdef FC_SEQ_TIMEOUT_EN
        chk("err_sticky", err_timeout, 1);
`else
        chk("err_tied_low", err_timeout, 0);
`endif
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_seq_ctrl.md
FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

Interface
REQ-001 SHALL have parameter BEATS, default 25, the number of 16-bit beats per FC frame.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, the number of FC scores searched.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the WAIT-state watchdog limit.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream beat valid.
REQ-007 SHALL have port s_ready, output, 1 bit: upstream beat accepted when s_valid and s_ready are both high.
REQ-008 SHALL have port s_data, input, 16 bits: binarized pixels; bit0 maps to FC pixel 1.
REQ-009 SHALL have port fc_valid_in, output, 1 bit: beat strobe to the FC layer.
REQ-010 SHALL have port fc_pixels, output, 16 bits: pixels to the FC layer.
REQ-011 SHALL have port fc_valid_out, input, 1 bit: FC result strobe.
REQ-012 SHALL have port fc_scores, input, 90 bits: score k (9-bit popcount) on bits [9k+8:9k].
REQ-013 SHALL have port m_valid, output, 1 bit: classification result valid.
REQ-014 SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port m_class, output, 4 bits: argmax index, 0..9.
REQ-016 SHALL have port m_score, output, 9 bits: the winning score.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than FEED, or in FEED with beat count nonzero.
REQ-018 SHALL have port err_timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-019 SHALL implement states FEED, WAIT, SCAN and OUT.
REQ-020 SHALL drive, in FEED, s_ready=1, fc_valid_in=s_valid, and fc_pixels=s_data combinationally (zero latency).
REQ-021 SHALL drive s_ready=0, fc_valid_in=0 and fc_pixels=0 outside FEED.
REQ-022 SHALL count accepted beats 0..BEATS-1; on the BEATS-th accepted beat, clear the count and go to WAIT.
REQ-023 SHALL hold the count through cycles with s_valid=0 in FEED; gaps are legal.
REQ-024 SHALL, in WAIT, on fc_valid_out=1, register all NUM_CLASSES scores and go to SCAN.
REQ-025 SHALL ignore fc_valid_out in FEED, SCAN and OUT.
REQ-026 SHALL, in SCAN, examine one score per cycle, index 0..NUM_CLASSES-1, taking best=score0 at index 0.
REQ-027 SHALL replace best only when score[idx] > best (strict), so ties resolve to the lowest index.
REQ-028 SHALL, after index NUM_CLASSES-1, register m_class and m_score and go to OUT.
REQ-029 SHALL first assert m_valid on the 11th rising edge after the edge that samples fc_valid_out.
REQ-030 SHALL hold m_valid, m_class and m_score stable in OUT until m_valid and m_ready are both high.
REQ-031 SHALL go to FEED on that handshake, with s_ready=1 on the next cycle.
REQ-032 SHALL treat m_ready as don't-care outside OUT.
REQ-033 SHALL keep scores unsigned and compare with a 9-bit comparison.

Reset
REQ-034 SHALL, on rst_n low at any time (including mid-frame), asynchronously go to FEED with beat count 0, scan index 0, m_valid=0, m_class=0, m_score=0, err_timeout=0 and busy=0.
REQ-035 SHALL discard a partially fed frame on reset; the FC layer shares rst_n and is realigned by it.

Configuration
REQ-036 SHALL, with macro FC_SEQ_TIMEOUT_EN defined, count cycles in WAIT.
REQ-037 SHALL, with FC_SEQ_TIMEOUT_EN defined, when TIMEOUT_CYCLES elapse without fc_valid_out, set err_timeout (cleared only by reset) and return to FEED with no output.
REQ-038 SHALL, with FC_SEQ_TIMEOUT_EN undefined, wait in WAIT indefinitely and tie err_timeout to 0.

Verification
REQ-039 SHALL cover: 25 back-to-back beats with an FC model returning scores at fc_valid_out 2 cycles after the last beat -> exactly 25 fc_valid_in pulses, then s_ready=0 until the output handshake.
REQ-040 SHALL cover: scores {100,150,210,90,...,0} -> m_class=2, m_score=210, m_valid rising 11 edges after fc_valid_out.
REQ-041 SHALL cover: scores with 205 at index 3 and index 7 -> m_class=3 (tie goes to the lowest index).
REQ-042 SHALL cover: m_ready held low for 20 cycles in OUT -> outputs stable and s_ready=0 throughout; handshake on release -> FEED.
REQ-043 SHALL cover: rst_n pulsed low after beat 12 -> busy=0, and the next frame needs 25 fresh beats.
REQ-044 SHALL cover: with FC_SEQ_TIMEOUT_EN, fc_valid_out withheld -> err_timeout=1 after 16 WAIT cycles, return to FEED, m_valid stays 0.
